// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite shared encodings (HTRANS, HSIZE, HRESP) and the slave-side FSM state type.
package ahb3lite_pkg;

  localparam int HTRANS_SIZE = 2;
  localparam int HSIZE_SIZE  = 3;

  localparam logic [HTRANS_SIZE-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [HSIZE_SIZE-1:0] HSIZE_BYTE  = 3'b000;
  localparam logic [HSIZE_SIZE-1:0] HSIZE_HWORD = 3'b001;
  localparam logic [HSIZE_SIZE-1:0] HSIZE_WORD  = 3'b010;
  localparam logic [HSIZE_SIZE-1:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

endpackage

// File: rtl/ahb3lite_sram_be.sv
// HSIZE + byte offset to byte-lane enables for a DATA_SIZE bus, with misalign and
// oversize flags. Offset bits below the transfer size are ignored when forming lanes.
module ahb3lite_sram_be
  import ahb3lite_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic [HSIZE_SIZE-1:0]         size,
  input  logic [$clog2(DATA_SIZE/8)-1:0] offset,
  output logic [DATA_SIZE/8-1:0]         be,
  output logic                           misalign,
  output logic                           oversize
);

  localparam int NB    = DATA_SIZE / 8;
  localparam int OFF_W = $clog2(NB);

  logic [OFF_W-1:0] mask;

  always_comb begin
    be       = '0;
    misalign = 1'b0;
    mask     = '0;
    oversize = (int'(size) > OFF_W);
    if (!oversize) begin
      mask     = OFF_W'((1 << size) - 1);
      misalign = |(offset & mask);
      // 2**size contiguous lanes starting at the size-aligned offset
      be       = NB'(((1 << (1 << size)) - 1) << (offset & ~mask));
    end
  end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM responder with WAIT_STATES wait cycles per beat and two-cycle ERROR.
// Optional build macro AHB3LITE_SRAM_ALIGN_CHECK_EN: misaligned transfers get ERROR.
module ahb3lite_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int DATA_SIZE   = 32,
  parameter int ADDR_SIZE   = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [ADDR_SIZE-1:0]   HADDR,
  input  logic [DATA_SIZE-1:0]   HWDATA,
  output logic [DATA_SIZE-1:0]   HRDATA,
  input  logic                   HWRITE,
  input  logic [HSIZE_SIZE-1:0]  HSIZE,
  input  logic [2:0]             HBURST,
  input  logic [3:0]             HPROT,
  input  logic [HTRANS_SIZE-1:0] HTRANS,
  input  logic                   HMASTLOCK,
  input  logic                   HREADY,
  output logic                   HREADYOUT,
  output logic                   HRESP
);

  localparam int NB       = DATA_SIZE / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int WADDR_W  = ADDR_SIZE - ADDR_LSB;
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  slave_state_t         state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [IDX_W-1:0]     d_idx;
  logic [NB-1:0]        d_be;
  logic                 d_write;
  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  logic [WADDR_W-1:0]   a_waddr;
  logic [NB-1:0]        a_be;
  logic                 a_misalign, a_oversize, a_illegal;
  logic                 accept, take_accept, load, beat_done;

  ahb3lite_sram_be #(.DATA_SIZE(DATA_SIZE)) u_be (
    .size     (HSIZE),
    .offset   (HADDR[ADDR_LSB-1:0]),
    .be       (a_be),
    .misalign (a_misalign),
    .oversize (a_oversize)
  );

  assign a_waddr   = HADDR[ADDR_SIZE-1:ADDR_LSB];
  assign accept    = HSEL & HREADY & HTRANS[1];
  assign beat_done = (state == ST_DATA) && (cnt == 4'd0);

`ifdef AHB3LITE_SRAM_ALIGN_CHECK_EN
  assign a_illegal = (a_waddr >= WADDR_W'(MEM_DEPTH)) | a_oversize | a_misalign;
`else
  logic unused_misalign;
  assign unused_misalign = a_misalign;
  assign a_illegal = (a_waddr >= WADDR_W'(MEM_DEPTH)) | a_oversize;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      d_idx   <= '0;
      d_be    <= '0;
      d_write <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        d_idx   <= a_waddr[IDX_W-1:0];
        d_be    <= a_be;
        d_write <= HWRITE;
      end
    end
  end

  // An address phase is only looked at where the previous beat is finishing
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    HREADYOUT   = 1'b1;
    HRESP       = HRESP_OKAY;
    take_accept = 1'b0;
    load        = 1'b0;
    case (state)
      ST_IDLE: take_accept = 1'b1;
      ST_DATA: begin
        HREADYOUT = (cnt == 4'd0);
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else take_accept = 1'b1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP       = HRESP_ERROR;
        take_accept = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (take_accept) begin
      if (!accept) begin
        state_nxt = ST_IDLE;
      end else if (a_illegal) begin
        state_nxt = ST_ERR1;
      end else begin
        state_nxt = ST_DATA;
        cnt_nxt   = 4'(WAIT_STATES);
        load      = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && beat_done && d_write) begin
      for (int b = 0; b < NB; b++) begin
        if (d_be[b]) mem[d_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = (state == ST_DATA) ? mem[d_idx] : '0;

endmodule
